// File: rtl/seg_hex_scan.sv
// Multiplexed hex seven-segment scanner with tear-free frame-synchronous updates,
// per-digit blank/blink/decimal point and live leading-zero suppression.
module seg_hex_scan #(
  parameter int unsigned N_DIGITS     = 4,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLINK_FRAMES = 25
) (
  input  logic                    iCLK,
  input  logic                    iRST,
  input  logic [4*N_DIGITS-1:0]   iDATA,
  input  logic                    iLOAD,
  input  logic [N_DIGITS-1:0]     iDP,
  input  logic [N_DIGITS-1:0]     iBLANK,
  input  logic [N_DIGITS-1:0]     iBLINK,
  input  logic                    iLZS,
  output logic [6:0]              oHEX_D,
  output logic                    oDP,
  output logic [N_DIGITS-1:0]     oDIG_SEL,
  output logic                    oFRAME
);

  localparam int unsigned IdxW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned PreW = $clog2(SCAN_DIV);
  localparam int unsigned BlkW = $clog2(BLINK_FRAMES + 1);

  typedef struct packed {
    logic [4*N_DIGITS-1:0] data;
    logic [N_DIGITS-1:0]   dp;
    logic [N_DIGITS-1:0]   blank;
    logic [N_DIGITS-1:0]   blink;
  } disp_t;

  logic [PreW-1:0]     presc_q, presc_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [BlkW-1:0]     blk_cnt_q, blk_cnt_d;
  logic                phase_q, phase_d;
  disp_t               pend_q, pend_d, act_q, act_d;
  logic [6:0]          hex_q, hex_d;
  logic                dp_q, dp_d;
  logic [N_DIGITS-1:0] sel_q, sel_d;
  logic                frame_q;

  logic                tc, frame;
  logic [N_DIGITS-1:0] lz;
  logic                lz_run;
  logic [3:0]          nib;
  logic                blank_now;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0:    hex7 = 7'b1000000;
      4'h1:    hex7 = 7'b1111001;
      4'h2:    hex7 = 7'b0100100;
      4'h3:    hex7 = 7'b0110000;
      4'h4:    hex7 = 7'b0011001;
      4'h5:    hex7 = 7'b0010010;
      4'h6:    hex7 = 7'b0000010;
      4'h7:    hex7 = 7'b1111000;
      4'h8:    hex7 = 7'b0000000;
      4'h9:    hex7 = 7'b0011000;
      4'hA:    hex7 = 7'b0001000;
      4'hB:    hex7 = 7'b0000011;
      4'hC:    hex7 = 7'b1000110;
      4'hD:    hex7 = 7'b0100001;
      4'hE:    hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  // Scan timing, blink phase and the pending/active double buffer.
  always_comb begin
    tc        = (presc_q == PreW'(SCAN_DIV - 1));
    frame     = tc && (idx_q == IdxW'(N_DIGITS - 1));
    presc_d   = tc ? '0 : presc_q + 1'b1;
    idx_d     = idx_q;
    blk_cnt_d = blk_cnt_q;
    phase_d   = phase_q;
    if (tc) idx_d = frame ? '0 : idx_q + 1'b1;
    if (frame) begin
      if (blk_cnt_q == BlkW'(BLINK_FRAMES - 1)) begin
        blk_cnt_d = '0;
        phase_d   = ~phase_q;
      end else begin
        blk_cnt_d = blk_cnt_q + 1'b1;
      end
    end
    pend_d = iLOAD ? disp_t'{data: iDATA, dp: iDP, blank: iBLANK, blink: iBLINK} : pend_q;
    // Active takes the value pending before this edge, so a coincident load waits a frame.
    act_d  = frame ? pend_q : act_q;
  end

  // Digit rendering for the currently selected index.
  always_comb begin
    lz     = '0;
    lz_run = iLZS;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      lz_run = lz_run & (act_q.data[4*k +: 4] == 4'h0) & ~act_q.dp[k];
      lz[k]  = lz_run;
    end
    nib       = act_q.data[4*int'(idx_q) +: 4];
    blank_now = act_q.blank[idx_q] | (act_q.blink[idx_q] & phase_q) | lz[idx_q];
    hex_d     = blank_now ? 7'b1111111 : hex7(nib);
    dp_d      = blank_now | ~act_q.dp[idx_q];
    sel_d     = ~(N_DIGITS'(1) << idx_q);
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      presc_q   <= '0;
      idx_q     <= '0;
      blk_cnt_q <= '0;
      phase_q   <= 1'b0;
      pend_q    <= '0;
      act_q     <= '0;
      hex_q     <= 7'b1111111;
      dp_q      <= 1'b1;
      sel_q     <= '1;
      frame_q   <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      blk_cnt_q <= blk_cnt_d;
      phase_q   <= phase_d;
      pend_q    <= pend_d;
      act_q     <= act_d;
      hex_q     <= hex_d;
      dp_q      <= dp_d;
      sel_q     <= sel_d;
      frame_q   <= frame;
    end
  end

  assign oHEX_D   = hex_q;
  assign oDP      = dp_q;
  assign oDIG_SEL = sel_q;
  assign oFRAME   = frame_q;

endmodule

// File: tb/tb_seg_hex_scan.sv
// Randomized bench for seg_hex_scan against a cycle-count based reference model.
module tb_seg_hex_scan;

  localparam int N  = 4;
  localparam int SD = 4;
  localparam int BF = 2;
  localparam int FL = SD * N;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data = '0;
  logic [3:0]  dp = '0, blank = '0, blink = '0;
  logic        load = 1'b0, lzs = 1'b0;
  logic [6:0]  hex;
  logic        odp;
  logic [3:0]  sel;
  logic        frm;

  seg_hex_scan #(.N_DIGITS(N), .SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .iCLK(clk), .iRST(rst), .iDATA(data), .iLOAD(load), .iDP(dp), .iBLANK(blank),
    .iBLINK(blink), .iLZS(lzs), .oHEX_D(hex), .oDP(odp), .oDIG_SEL(sel), .oFRAME(frm)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  logic [6:0] hex_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Model state: non-reset edges since reset, plus pending and active contents.
  int          c = 0;
  logic [15:0] p_data = '0, a_data = '0;
  logic [3:0]  p_dp = '0, a_dp = '0, p_bl = '0, a_bl = '0, p_bk = '0, a_bk = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
  endtask

  task automatic step();
    logic [6:0] e_hex;
    logic       e_dp, e_frm, bl;
    logic [3:0] e_sel;
    int         idx, ph, top;
    @(posedge clk);
    if (rst) begin
      e_hex = 7'h7f; e_dp = 1'b1; e_sel = 4'hf; e_frm = 1'b0;
      c = 0;
      p_data = '0; p_dp = '0; p_bl = '0; p_bk = '0;
      a_data = '0; a_dp = '0; a_bl = '0; a_bk = '0;
    end else begin
      idx = (c / SD) % N;
      ph  = ((c / FL) / BF) % 2;
      top = 0;
      for (int k = 0; k < N; k++) if (a_data[4*k +: 4] != 4'h0 || a_dp[k]) top = k;
      bl    = a_bl[idx] || (a_bk[idx] && ph == 1) || (lzs && idx > top);
      e_hex = bl ? 7'h7f : hex_tab[a_data[4*idx +: 4]];
      e_dp  = bl ? 1'b1 : ~a_dp[idx];
      e_sel = ~(4'b0001 << idx);
      e_frm = (c % FL) == FL - 1;
      if (e_frm) begin
        a_data = p_data; a_dp = p_dp; a_bl = p_bl; a_bk = p_bk;
      end
      if (load) begin
        p_data = data; p_dp = dp; p_bl = blank; p_bk = blink;
      end
      c++;
    end
    #1;
    check("hex", 32'(hex), 32'(e_hex));
    check("dp", 32'(odp), 32'(e_dp));
    check("dig_sel", 32'(sel), 32'(e_sel));
    check("frame", 32'(frm), 32'(e_frm));
  endtask

  task automatic tick();
    step();
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b,
                         input logic [3:0] k);
    data = d; dp = p; blank = b; blink = k; load = 1'b1;
    tick();
  endtask

  initial begin
    run(3);
    rst = 1'b0;
    tick();
    check("release_sel", 32'(sel), 32'h0000_000e);
    check("release_hex", 32'(hex), 32'h0000_0040);
    run(40);

    do_load(16'h12AF, 4'h0, 4'h0, 4'h0);
    run(40);
    lzs = 1'b1;
    do_load(16'h0050, 4'h0, 4'h0, 4'h0);
    run(36);
    do_load(16'h0050, 4'b0100, 4'h0, 4'h0);
    run(36);
    lzs = 1'b0;
    do_load(16'h0001, 4'h0, 4'h0, 4'b0001);
    run(5 * FL);

    // Load landing on the internal frame edge must wait one more frame.
    do_load(16'h1111, 4'h0, 4'h0, 4'h0);
    while ((c % FL) != FL - 1) tick();
    do_load(16'h3333, 4'h0, 4'h0, 4'h0);
    run(3 * FL);

    // Reset mid-scan while digit 2 is selected.
    while (((c / SD) % N) != 2) tick();
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    run(2 * FL);

    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        for (int k = 0; k < N; k++) data[4*k +: 4] = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
        dp    = 4'($urandom) & 4'($urandom);
        blank = 4'($urandom) & 4'($urandom) & 4'($urandom);
        blink = 4'($urandom) & 4'($urandom);
        load  = 1'b1;
      end
      if ($urandom_range(0, 31) == 0) lzs = ~lzs;
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    run(FL);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
